spi_xfer_sequencer: RTL and testbench

//  Master-mode word sequencer for the SPI core. Pops words from TX FIFO, starts each shift in the clock/shift unit.

---
 rtl/spi_xfer_sequencer_pkg.sv | 33 +++
 rtl/spi_seq_delay_cnt.sv | 38 +++
 rtl/spi_xfer_sequencer.sv | 176 +++++++++++++++++
 tb/tb_spi_xfer_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_xfer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_xfer_sequencer_pkg
// Brief   : Shared types and constants for the SPI master word sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package spi_xfer_sequencer_pkg;

  // Number of slave-select lines and width of the inter-word delay field
  localparam int SPI_SS_NUM = 4;
  localparam int SPI_TXDL_W = 8;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    DELAY   = 3'd4
  } spi_seq_state_e;

  // Control-register fields consumed by the sequencer
  typedef struct packed {
    logic                  spie;
    logic                  swr;
    logic                  mstr;
    logic                  talk;
    logic [1:0]            ss;
    logic [SPI_TXDL_W-1:0] txdl;
  } sc2seq;

endpackage : spi_xfer_sequencer_pkg
`default_nettype wire

// File: rtl/spi_seq_delay_cnt.sv
`default_nettype none
// ============================================================================
// Module  : spi_seq_delay_cnt
// Brief   : Loadable down-counter for the inter-word delay. Holds at zero;
//           o_zero flags the final delay cycle.
// Revision: 1.0 - initial release
// ============================================================================
module spi_seq_delay_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  // Counter register: clear has priority over load, load over decrement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule : spi_seq_delay_cnt
`default_nettype wire

// File: rtl/spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : spi_xfer_sequencer
// Brief   : Master-mode word sequencer. Pops TX words, starts the shifter,
//           pushes RX words, drives slave selects, inserts the inter-word
//           delay and pulses trc_int when the TX FIFO drains.
//           Build option SPI_RXSTALL_EN: hold in CAPTURE while the RX FIFO
//           is full instead of dropping the received word.
// Revision: 1.0 - initial release
// ============================================================================
module spi_xfer_sequencer
  import spi_xfer_sequencer_pkg::*;
#(
  parameter int SS_NUM     = SPI_SS_NUM,
  parameter int TXDL_WIDTH = SPI_TXDL_W
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  spie,
  input  logic                  swr,
  input  logic                  mstr,
  input  logic                  talk,
  input  logic [1:0]            ss_sel,
  input  logic [TXDL_WIDTH-1:0] txdl,
  input  logic                  tfifo_empty,
  input  logic                  rfifo_full,
  input  logic                  shift_done,
  output logic                  tfifo_ren,
  output logic                  shift_load,
  output logic                  transfer_start,
  output logic                  rfifo_wen,
  output logic [SS_NUM-1:0]     ss_n,
  output logic                  busy,
  output logic                  trc_int,
  output logic                  rx_drop
);

  spi_seq_state_e    r_state;
  spi_seq_state_e    w_state_nxt;
  logic [1:0]        r_ss;
  logic              r_trc;
  logic              w_abort;
  logic              w_ss_cap;
  logic              w_trc_set;
  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic              w_cnt_zero;
  logic              w_tfifo_ren;
  logic              w_shift_load;
  logic              w_rfifo_wen;
  logic              w_rx_drop;
  logic [SS_NUM-1:0] w_ss_onehot;

  // Soft reset or leaving master mode aborts the sequence immediately
  assign w_abort = swr | ~mstr;

  // Inter-word delay counter, loaded on entry to DELAY
  spi_seq_delay_cnt #(
    .WIDTH (TXDL_WIDTH)
  ) u_delay_cnt (
    .clk        (pclk),
    .rst_n      (preset_n),
    .i_clr      (w_abort),
    .i_load     (w_cnt_load),
    .i_load_val (txdl),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // State, latched slave index and transfer-complete pulse registers
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state <= IDLE;
      r_ss    <= 2'd0;
      r_trc   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_trc   <= w_trc_set;
      if (w_ss_cap) begin
        r_ss <= ss_sel;
      end
    end
  end

  // Next-state and pulse decode; an abort overrides everything at the end
  always_comb begin
    w_state_nxt  = r_state;
    w_tfifo_ren  = 1'b0;
    w_shift_load = 1'b0;
    w_rfifo_wen  = 1'b0;
    w_rx_drop    = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    w_trc_set    = 1'b0;
    w_ss_cap     = 1'b0;
    case (r_state)
      IDLE: begin
        if (spie && !tfifo_empty) begin
          w_tfifo_ren = 1'b1;
          w_ss_cap    = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_shift_load = 1'b1;
        w_state_nxt  = SHIFT;
      end
      SHIFT: begin
        if (shift_done) begin
          w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!talk) begin
          w_cnt_load  = 1'b1;
          w_state_nxt = DELAY;
        end else if (!rfifo_full) begin
          w_rfifo_wen = 1'b1;
          w_cnt_load  = 1'b1;
          w_state_nxt = DELAY;
        end else begin
`ifdef SPI_RXSTALL_EN
          // Hold with the slave still selected until the RX FIFO has room
          w_state_nxt = CAPTURE;
`else
          // No room: the received word is lost and flagged
          w_rx_drop   = 1'b1;
          w_cnt_load  = 1'b1;
          w_state_nxt = DELAY;
`endif
        end
      end
      DELAY: begin
        if (w_cnt_zero) begin
          if (spie && !tfifo_empty) begin
            w_tfifo_ren = 1'b1;
            w_state_nxt = LOAD;
          end else begin
            w_trc_set   = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_abort) begin
      w_state_nxt  = IDLE;
      w_tfifo_ren  = 1'b0;
      w_shift_load = 1'b0;
      w_rfifo_wen  = 1'b0;
      w_rx_drop    = 1'b0;
      w_cnt_load   = 1'b0;
      w_cnt_dec    = 1'b0;
      w_trc_set    = 1'b0;
      w_ss_cap     = 1'b0;
    end
  end

  // One-hot select of the slave latched when the sequence started
  assign w_ss_onehot = SS_NUM'(1) << r_ss;

  assign tfifo_ren      = w_tfifo_ren;
  assign shift_load     = w_shift_load;
  assign transfer_start = w_shift_load;
  assign rfifo_wen      = w_rfifo_wen;
  assign rx_drop        = w_rx_drop;
  assign busy           = (r_state != IDLE);
  assign ss_n           = (r_state != IDLE) ? ~w_ss_onehot : {SS_NUM{1'b1}};
  assign trc_int        = r_trc;

endmodule : spi_xfer_sequencer
`default_nettype wire

// File: tb/tb_spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_xfer_sequencer
// Brief   : Self-checking bench for spi_xfer_sequencer. Each burst is
//           described by a cycle timeline computed from word timing rules;
//           every cycle the DUT outputs are compared with that timeline.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_xfer_sequencer;

  localparam int MAXC = 512;

  logic       pclk        = 1'b0;
  logic       preset_n    = 1'b0;
  logic       spie        = 1'b0;
  logic       swr         = 1'b0;
  logic       mstr        = 1'b1;
  logic       talk        = 1'b0;
  logic [1:0] ss_sel      = 2'd0;
  logic [7:0] txdl        = 8'd0;
  logic       tfifo_empty = 1'b1;
  logic       rfifo_full  = 1'b0;
  logic       shift_done  = 1'b0;
  logic       tfifo_ren;
  logic       shift_load;
  logic       transfer_start;
  logic       rfifo_wen;
  logic [3:0] ss_n;
  logic       busy;
  logic       trc_int;
  logic       rx_drop;

  int checks   = 0;
  int failures = 0;
  int tx_count = 0;

  // Expected timeline and stimulus, indexed by cycle within a burst
  bit e_ren   [MAXC];
  bit e_start [MAXC];
  bit e_wen   [MAXC];
  bit e_drop  [MAXC];
  bit e_trc   [MAXC];
  bit e_busy  [MAXC];
  bit sd_stim [MAXC];
  bit full_stim[MAXC];
  bit in_shift[MAXC];

  logic [10:0] obs_v;
  assign obs_v = {tfifo_ren, shift_load, transfer_start, rfifo_wen, rx_drop,
                  trc_int, busy, ss_n};

  spi_xfer_sequencer #(
    .SS_NUM     (4),
    .TXDL_WIDTH (8)
  ) dut (
    .pclk           (pclk),
    .preset_n       (preset_n),
    .spie           (spie),
    .swr            (swr),
    .mstr           (mstr),
    .talk           (talk),
    .ss_sel         (ss_sel),
    .txdl           (txdl),
    .tfifo_empty    (tfifo_empty),
    .rfifo_full     (rfifo_full),
    .shift_done     (shift_done),
    .tfifo_ren      (tfifo_ren),
    .shift_load     (shift_load),
    .transfer_start (transfer_start),
    .rfifo_wen      (rfifo_wen),
    .ss_n           (ss_n),
    .busy           (busy),
    .trc_int        (trc_int),
    .rx_drop        (rx_drop)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input int c, input logic [10:0] exp);
    checks++;
    assert (obs_v === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b (ren,load,start,wen,drop,trc,busy,ss_n)",
             tag, c, obs_v, exp);
    end
  endtask

  // abort_kind: 0 none, 1 swr in SHIFT, 2 mstr low in SHIFT, 3 preset_n pulse in DELAY
  // hold_mode : 0 RX never full, 1 random full windows, 2 first word sees 10 full cycles
  task automatic run_burst(input string tag, input int n, input int dl, input int ss,
                           input bit tk, input int drop_word, input int abort_kind,
                           input int hold_mode);
    int L[4];
    int H[4];
    int nw, s, d, cap, ext, nxt, busy_end, abort_at, spie_off, last, len;
    logic [3:0]  sel;
    logic [10:0] exp;
    for (int c = 0; c < MAXC; c++) begin
      e_ren[c] = 0; e_start[c] = 0; e_wen[c] = 0; e_drop[c] = 0; e_trc[c] = 0;
      e_busy[c] = 0; sd_stim[c] = 0; full_stim[c] = 0; in_shift[c] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      L[k] = $urandom_range(1, 6);
      H[k] = (hold_mode == 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
    end
    if (hold_mode == 2) H[0] = 10;
    if (abort_kind == 1 || abort_kind == 2) L[0] = $urandom_range(3, 6);
    if (abort_kind == 3) H[0] = 0;
    nw = (drop_word >= 0) ? drop_word + 1 : n;
    if (abort_kind != 0) nw = 1;
    s = 1; busy_end = 0; abort_at = MAXC; spie_off = MAXC; last = 0;
    e_ren[0] = 1;
    for (int k = 0; k < nw; k++) begin
      e_start[s] = 1;
      d = s + L[k];
      sd_stim[d] = 1;
      for (int c = s + 1; c <= d; c++) in_shift[c] = 1;
      if (k == drop_word) spie_off = s + 1;
      if (abort_kind == 1 || abort_kind == 2) begin
        abort_at = s + 1 + $urandom_range(0, L[k] - 2);
        busy_end = abort_at;
        last     = d;
        break;
      end
      cap = d + 1;
      ext = 0;
      for (int c = cap; c < cap + H[k]; c++) full_stim[c] = 1;
      if (tk && H[k] > 0) begin
`ifdef SPI_RXSTALL_EN
        ext = H[k];
        e_wen[cap + ext] = 1;
`else
        e_drop[cap] = 1;
`endif
      end else if (tk) begin
        e_wen[cap] = 1;
      end
      // DELAY occupies dl+1 cycles after CAPTURE; next LOAD follows it
      nxt = cap + ext + dl + 2;
      if (abort_kind == 3) begin
        abort_at = cap + ext + 1 + $urandom_range(0, dl);
        busy_end = abort_at - 1;
        last     = abort_at;
        break;
      end
      if (k < nw - 1) begin
        e_ren[nxt - 1] = 1;
        s = nxt;
      end else begin
        e_trc[nxt] = 1;
        busy_end   = nxt - 1;
        last       = nxt;
      end
    end
    for (int c = 1; c <= busy_end; c++) e_busy[c] = 1;
    // Stray shift_done pulses outside SHIFT must have no effect
    for (int c = 0; c < last + 6; c++)
      if (!in_shift[c] && !sd_stim[c] && $urandom_range(0, 3) == 0) sd_stim[c] = 1;
    len = last + 8;
    tx_count = n; ss_sel = 2'(ss); txdl = 8'(dl); talk = tk;
    for (int c = 0; c < len; c++) begin
      @(negedge pclk);
      spie        = (c < spie_off) && !(abort_kind == 3 && c >= abort_at);
      swr         = (abort_kind == 1 && c >= abort_at);
      mstr        = !(abort_kind == 2 && c >= abort_at);
      preset_n    = !(abort_kind == 3 && c == abort_at);
      tfifo_empty = (tx_count == 0);
      shift_done  = sd_stim[c];
      rfifo_full  = full_stim[c];
      if (c == 1) ss_sel = 2'($urandom);
      #1;
      sel = 4'b0001 << ss;
      exp = {e_ren[c], e_start[c], e_start[c], e_wen[c], e_drop[c], e_trc[c],
             e_busy[c], e_busy[c] ? ~sel : 4'hF};
      check(tag, c, exp);
      if (tfifo_ren && tx_count > 0) tx_count--;
    end
    @(negedge pclk);
    spie = 0; swr = 0; mstr = 1; preset_n = 1; tx_count = 0;
    tfifo_empty = 1; shift_done = 0; rfifo_full = 0;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge pclk);
    #1;
    check("reset", 0, {7'b0, 4'hF});
    @(negedge pclk);
    preset_n = 1;
    #1;
    check("post_reset_idle", 0, {7'b0, 4'hF});

    run_burst("T1_two_words_txdl0",  2, 0, 0, 1'b1, -1, 0, 0);
    run_burst("T2_txdl5_ss2",        2, 5, 2, 1'b1, -1, 0, 0);
    run_burst("T3_rx_full_hold",     2, 1, 1, 1'b1, -1, 0, 2);
    run_burst("T3_full_no_talk",     2, 2, 3, 1'b0, -1, 0, 2);
    run_burst("T4_swr_in_shift",     2, 3, 1, 1'b1, -1, 1, 0);
    run_burst("T4_mstr_drop",        3, 2, 2, 1'b1, -1, 2, 0);
    run_burst("T5_spie_clear",       3, 2, 3, 1'b1,  0, 0, 0);

    // mstr low keeps the sequencer parked even with data queued
    mstr = 0; spie = 1; tx_count = 3; tfifo_empty = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge pclk);
      shift_done = c[0];
      #1;
      check("T6_mstr_idle", c, {7'b0, 4'hF});
    end
    @(negedge pclk);
    mstr = 1; spie = 0; tx_count = 0; tfifo_empty = 1; shift_done = 0;

    run_burst("T6_preset_in_delay",  2, 10, 2, 1'b1, -1, 3, 0);

    for (int i = 0; i < 12; i++) begin
      run_burst("rand_burst", $urandom_range(1, 4), $urandom_range(0, 6),
                $urandom_range(0, 3), 1'($urandom), -1, 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_spi_xfer_sequencer
`default_nettype wire
